// File: rtl/bcd_stopwatch_gen_if.sv
// Control and status bundle between the button logic, the stopwatch core and the display mux.
// master drives the controls; slave is the stopwatch core.
interface bcd_stopwatch_gen_if #(
   parameter int unsigned DIGITS = 4
);
   logic                  go;
   logic                  clr;
   logic                  dir;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic                  lap;
   logic [4*DIGITS-1:0]   count;
   logic [4*DIGITS-1:0]   disp;
   logic                  lap_active;
   logic                  tick;
   logic                  wrap;

   modport master (
      output go, clr, dir, load, load_val, lap,
      input  count, disp, lap_active, tick, wrap
   );

   modport slave (
      input  go, clr, dir, load, load_val, lap,
      output count, disp, lap_active, tick, wrap
   );
endinterface

// File: rtl/bcd_stopwatch_gen.sv
// Parametrised BCD stopwatch: up/down digit chain behind a tick divider, with clear, load,
// lap freeze and tick/wrap status pulses.
module bcd_stopwatch_gen #(
   parameter int unsigned DIGITS  = 4,
   parameter int unsigned CLK_DIV = 5_000_000,
   parameter int unsigned DIV_W   = 23
) (
   input logic                clk,
   input logic                rst_n,
   bcd_stopwatch_gen_if.slave bus
);
   localparam int unsigned      W        = 4 * DIGITS;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [W-1:0]     count_q, count_d;
   logic [W-1:0]     snap_q, snap_d;
   logic             lap_active_q, lap_active_d;
   logic             tick_q, tick_d;
   logic             wrap_q, wrap_d;
   logic [W-1:0]     stepped;
   logic [W-1:0]     clamped;
   logic             chain_wrap;

   // Ripple carry/borrow through the digits; a carry out of the top digit is a full wrap.
   always_comb begin : step_chain
      logic       carry;
      logic [3:0] dig;
      carry   = 1'b1;
      dig     = 4'd0;
      stepped = count_q;
      for (int k = 0; k < DIGITS; k++) begin
         dig = count_q[4*k +: 4];
         if (carry) begin
            if (!bus.dir) begin
               if (dig >= 4'd9) begin
                  stepped[4*k +: 4] = 4'd0;
               end else begin
                  stepped[4*k +: 4] = dig + 4'd1;
                  carry             = 1'b0;
               end
            end else begin
               if (dig == 4'd0) begin
                  stepped[4*k +: 4] = 4'd9;
               end else begin
                  stepped[4*k +: 4] = dig - 4'd1;
                  carry             = 1'b0;
               end
            end
         end
      end
      chain_wrap = carry;
   end

   always_comb begin : load_clamp
      clamped = '0;
      for (int k = 0; k < DIGITS; k++) begin
         clamped[4*k +: 4] = (bus.load_val[4*k +: 4] > 4'd9) ? 4'd9 : bus.load_val[4*k +: 4];
      end
   end

   always_comb begin : next_state
      div_cnt_d    = div_cnt_q;
      count_d      = count_q;
      snap_d       = snap_q;
      lap_active_d = lap_active_q;
      tick_d       = 1'b0;
      wrap_d       = 1'b0;
      if (bus.clr) begin
         count_d      = '0;
         div_cnt_d    = '0;
         lap_active_d = 1'b0;
      end else begin
         if (bus.load) begin
            count_d   = clamped;
            div_cnt_d = '0;
         end else if (bus.go) begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               count_d   = stepped;
               tick_d    = 1'b1;
               wrap_d    = chain_wrap;
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end
         // Snapshot takes the pre-edge count, so a coincident step is not captured.
         if (bus.lap) begin
            if (!lap_active_q) begin
               snap_d       = count_q;
               lap_active_d = 1'b1;
            end else begin
               lap_active_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q    <= '0;
         count_q      <= '0;
         snap_q       <= '0;
         lap_active_q <= 1'b0;
         tick_q       <= 1'b0;
         wrap_q       <= 1'b0;
      end else begin
         div_cnt_q    <= div_cnt_d;
         count_q      <= count_d;
         snap_q       <= snap_d;
         lap_active_q <= lap_active_d;
         tick_q       <= tick_d;
         wrap_q       <= wrap_d;
      end
   end

   assign bus.count      = count_q;
   assign bus.disp       = lap_active_q ? snap_q : count_q;
   assign bus.lap_active = lap_active_q;
   assign bus.tick       = tick_q;
   assign bus.wrap       = wrap_q;
endmodule

// File: tb/tb_bcd_stopwatch_gen.sv
// Directed bench for bcd_stopwatch_gen (DIGITS=4, CLK_DIV=4): expected step results are queued
// by the stimulus and checked by a monitor whenever tick or wrap is seen.
module tb_bcd_stopwatch_gen;
   typedef struct packed {
      logic [15:0] count;
      logic        wrap;
   } exp_t;

   logic clk;
   logic rst_n;
   int   vectors;
   int   errors;
   exp_t exp_q[$];

   bcd_stopwatch_gen_if #(.DIGITS(4)) bus ();

   bcd_stopwatch_gen #(
      .DIGITS (4),
      .CLK_DIV(4),
      .DIV_W  (3)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input logic [15:0] v);
      bus.load     = 1'b1;
      bus.load_val = v;
      cyc(1);
      bus.load     = 1'b0;
   endtask

   task automatic pulse_lap();
      bus.lap = 1'b1;
      cyc(1);
      bus.lap = 1'b0;
   endtask

   task automatic push(input logic [15:0] c, input logic w);
      exp_t e;
      e.count = c;
      e.wrap  = w;
      exp_q.push_back(e);
   endtask

   // Monitor: every tick/wrap pulse must match the next queued step result.
   always @(negedge clk) begin
      if (rst_n && (bus.tick || bus.wrap)) begin
         if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_pulse: count %h tick %b wrap %b, expected no pulse",
                     bus.count, bus.tick, bus.wrap);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mon_tick", {31'd0, bus.tick}, 32'd1);
            chk("mon_count", {16'd0, bus.count}, {16'd0, e.count});
            chk("mon_wrap", {31'd0, bus.wrap}, {31'd0, e.wrap});
         end
      end
   end

   initial begin
      vectors      = 0;
      errors       = 0;
      rst_n        = 1'b1;
      bus.go       = 1'b0;
      bus.clr      = 1'b0;
      bus.dir      = 1'b0;
      bus.load     = 1'b0;
      bus.load_val = '0;
      bus.lap      = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_count", {16'd0, bus.count}, 32'd0);
      chk("rst_disp", {16'd0, bus.disp}, 32'd0);
      chk("rst_lap", {31'd0, bus.lap_active}, 32'd0);
      chk("rst_tick", {30'd0, bus.tick, bus.wrap}, 32'd0);
      cyc(2);
      rst_n = 1'b1;

      // 1: first step after a full divider period
      bus.go = 1'b1;
      push(16'h0001, 1'b0);
      push(16'h0002, 1'b0);
      cyc(3);
      chk("t1_before", {16'd0, bus.count}, 32'h0000);
      cyc(1);
      chk("t1_step1", {16'd0, bus.count}, 32'h0001);
      chk("t1_tick_hi", {31'd0, bus.tick}, 32'd1);
      cyc(1);
      chk("t1_tick_lo", {31'd0, bus.tick}, 32'd0);
      cyc(3);
      chk("t1_step2", {16'd0, bus.count}, 32'h0002);
      chk("t1_disp", {16'd0, bus.disp}, 32'h0002);
      bus.go = 1'b0;

      // 2: carry, full wrap up, load clamp
      do_load(16'h0099);
      chk("t2_load", {16'd0, bus.count}, 32'h0099);
      chk("t2_load_tick", {31'd0, bus.tick}, 32'd0);
      push(16'h0100, 1'b0);
      bus.go = 1'b1;
      cyc(4);
      bus.go = 1'b0;
      chk("t2_carry", {16'd0, bus.count}, 32'h0100);
      chk("t2_nowrap", {31'd0, bus.wrap}, 32'd0);
      do_load(16'h9999);
      push(16'h0000, 1'b1);
      bus.go = 1'b1;
      cyc(4);
      bus.go = 1'b0;
      chk("t2_wrap_count", {16'd0, bus.count}, 32'h0000);
      chk("t2_wrap_flags", {30'd0, bus.tick, bus.wrap}, 32'd3);
      do_load(16'h0F3A);
      chk("t2_clamp", {16'd0, bus.count}, 32'h0939);

      // 3: count down, borrow, wrap down, dir toggle mid-period
      bus.dir = 1'b1;
      do_load(16'h0100);
      push(16'h0099, 1'b0);
      bus.go = 1'b1;
      cyc(4);
      bus.go = 1'b0;
      chk("t3_borrow", {16'd0, bus.count}, 32'h0099);
      do_load(16'h0000);
      push(16'h9999, 1'b1);
      bus.go = 1'b1;
      cyc(4);
      bus.go = 1'b0;
      chk("t3_wrap_down", {16'd0, bus.count}, 32'h9999);
      chk("t3_wrap_flag", {31'd0, bus.wrap}, 32'd1);
      do_load(16'h0050);
      push(16'h0051, 1'b0);
      bus.go = 1'b1;
      cyc(2);
      bus.dir = 1'b0;
      cyc(2);
      bus.go = 1'b0;
      chk("t3_dir_toggle", {16'd0, bus.count}, 32'h0051);

      // 4: pause holds the divider
      do_load(16'h0000);
      push(16'h0001, 1'b0);
      bus.go = 1'b1;
      cyc(2);
      bus.go = 1'b0;
      cyc(10);
      chk("t4_paused", {16'd0, bus.count}, 32'h0000);
      bus.go = 1'b1;
      cyc(1);
      chk("t4_resume1", {16'd0, bus.count}, 32'h0000);
      cyc(1);
      bus.go = 1'b0;
      chk("t4_resume2", {16'd0, bus.count}, 32'h0001);

      // 5: lap freeze, release, coincident lap and step, load while frozen
      do_load(16'h0012);
      pulse_lap();
      chk("t5_lap_on", {31'd0, bus.lap_active}, 32'd1);
      chk("t5_lap_disp", {16'd0, bus.disp}, 32'h0012);
      push(16'h0013, 1'b0);
      push(16'h0014, 1'b0);
      push(16'h0015, 1'b0);
      bus.go = 1'b1;
      cyc(12);
      bus.go = 1'b0;
      chk("t5_live", {16'd0, bus.count}, 32'h0015);
      chk("t5_frozen", {16'd0, bus.disp}, 32'h0012);
      pulse_lap();
      chk("t5_lap_off", {31'd0, bus.lap_active}, 32'd0);
      chk("t5_unfrozen", {16'd0, bus.disp}, 32'h0015);
      do_load(16'h0019);
      push(16'h0020, 1'b0);
      bus.go = 1'b1;
      cyc(3);
      pulse_lap();
      bus.go = 1'b0;
      chk("t5_coinc_count", {16'd0, bus.count}, 32'h0020);
      chk("t5_coinc_snap", {16'd0, bus.disp}, 32'h0019);
      do_load(16'h0345);
      chk("t5_load_count", {16'd0, bus.count}, 32'h0345);
      chk("t5_load_disp", {16'd0, bus.disp}, 32'h0019);
      chk("t5_load_lap", {31'd0, bus.lap_active}, 32'd1);

      // 6: asynchronous reset between edges, then clear priority
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_count", {16'd0, bus.count}, 32'd0);
      chk("t6_rst_disp", {16'd0, bus.disp}, 32'd0);
      chk("t6_rst_lap", {31'd0, bus.lap_active}, 32'd0);
      cyc(1);
      rst_n = 1'b1;
      do_load(16'h0345);
      bus.go = 1'b1;
      cyc(2);
      bus.clr      = 1'b1;
      bus.load     = 1'b1;
      bus.load_val = 16'h0777;
      cyc(1);
      bus.clr      = 1'b0;
      bus.load     = 1'b0;
      chk("t6_clr_count", {16'd0, bus.count}, 32'h0000);
      chk("t6_clr_tick", {31'd0, bus.tick}, 32'd0);
      push(16'h0001, 1'b0);
      cyc(3);
      chk("t6_clr_before", {16'd0, bus.count}, 32'h0000);
      cyc(1);
      bus.go = 1'b0;
      chk("t6_clr_step", {16'd0, bus.count}, 32'h0001);
      pulse_lap();
      chk("t6_lap_set", {31'd0, bus.lap_active}, 32'd1);
      bus.clr = 1'b1;
      bus.lap = 1'b1;
      cyc(1);
      bus.clr = 1'b0;
      bus.lap = 1'b0;
      chk("t6_clr_lap", {31'd0, bus.lap_active}, 32'd0);

      cyc(3);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/bcd_stopwatch_gen.md
Name: bcd_stopwatch_gen

Overview:
Parametrised multi-digit BCD stopwatch/timer core and the successor to the fixed 3-digit up-counter.
- Adds:
  - generic digit count and tick divider;
  - up/down direction;
  - synchronous clear and parallel load;
  - lap (display freeze) capture;
  - tick and wrap status pulses.
- Sits between the button/debounce logic and the 7-segment display multiplexer.

Parameters:
DIGITS, 4, number of BCD digits in the count chain (1..8); digit 0 is least significant.
CLK_DIV, 5_000_000, number of clk cycles with go=1 per one LSD step (>=2).
DIV_W, 23, width of the divider register; must satisfy 2**DIV_W >= CLK_DIV.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
go  input  1  run enable; 0 pauses divider and count
clr  input  1  synchronous clear, single-cycle or level
dir  input  1  0 = count up, 1 = count down
load  input  1  synchronous parallel load strobe
load_val  input  4*DIGITS  BCD value for load; digit k at bits [4k+3:4k]
lap  input  1  single-cycle pulse; toggles lap freeze
count  output  4*DIGITS  live BCD count (registered)
disp  output  4*DIGITS  display value: lap snapshot while frozen, else count
lap_active  output  1  1 while disp is frozen
tick  output  1  one-cycle pulse on the edge count steps
wrap  output  1  one-cycle pulse on the edge count wraps

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed):
  - count, snapshot register, div_cnt, lap_active, tick, wrap all go to 0.
  - disp reads all zeros.
- Per-edge priority: clr > load > step. Lap handling is independent of that priority, except that clr overrides it.
- clr:
  - count=0, div_cnt=0, lap_active=0, tick=0, wrap=0.
  - Any lap pulse in the same cycle is ignored.
- load (clr=0):
  - count=load_val, div_cnt=0, tick=0, wrap=0.
  - Each digit >9 is clamped to 9 at load.
- Divider:
  - When go=1 and neither clr nor load is active: if div_cnt==CLK_DIV-1, div_cnt<=0 and a step occurs; else div_cnt<=div_cnt+1.
  - When go=0: div_cnt holds. This is a pause, not a restart.
- Step, up (dir=0): digit 0 increments. Any digit at 9 becomes 0 and carries into the next digit.
- Step, down (dir=1): digit 0 decrements. Any digit at 0 becomes 9 and borrows from the next digit.
- Full-chain wrap:
  - Up from all-9s gives all-0s; down from all-0s gives all-9s.
  - wrap=1 on that edge only.
- tick:
  - Registered; high for exactly the one cycle in which count first shows the stepped value.
  - Low on every other cycle, including load and clr cycles.
- dir is sampled at the step edge. A dir change never resets div_cnt.
- Lap:
  - lap=1 with lap_active=0: the snapshot register captures the current (pre-edge) count, and lap_active<=1.
  - lap=1 with lap_active=1: lap_active<=0.
- disp is a combinational mux: lap_active ? snapshot : count.
- Lap and step on the same edge: the snapshot holds the pre-step value; count takes the post-step value.
- load while lap_active=1: count loads, disp stays frozen, lap_active is unchanged.
- Reset mid-count or mid-lap: immediate return to the reset state. After rst_n deasserts, the first step needs a full CLK_DIV cycles of go=1.

Test Plan:
All scenarios use DIGITS=4, CLK_DIV=4.
1. Reset, go=1, dir=0 -> count=0x0001 on the 4th rising edge with tick=1 for that cycle only; count=0x0002 after 8 edges.
2. load 0x0099, go=1 for 4 edges -> count=0x0100, wrap=0. Then load 0x9999, step -> count=0x0000, wrap=1 and tick=1 on the same edge. Also load 0x0F3A -> count=0x0939.
3. dir=1: load 0x0100, step -> 0x0099; load 0x0000, step -> 0x9999 with wrap=1. Toggling dir mid-divider does not delay the step.
4. Pause: go=1 for 2 edges, go=0 for 10 edges, go=1 for 2 edges -> step on the 2nd edge after resuming, count=0x0001; no step while paused.
5. Lap:
   - At count=0x0012, pulse lap -> lap_active=1, disp=0x0012 while count advances to 0x0015.
   - Pulse lap again -> lap_active=0, disp=0x0015.
   - Lap coincident with a step from 0x0019 -> snapshot 0x0019, count 0x0020.
6. Reset/clear:
   - Drop rst_n between clock edges with count=0x0345 and lap_active=1 -> all outputs 0 before the next edge.
   - clr and load asserted together -> count=0x0000, div_cnt restarts; the next step comes after 4 go cycles.
